// File: rtl/id_ex_operand_stage_pkg.sv
// Shared definitions for the ID/EX operand stage: ALU op codes, default widths
// and the values an empty (bubble) stage presents to the ALU.
package id_ex_operand_stage_pkg;

  localparam int DW_DEF = 32;
  localparam int RW_DEF = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_OR  = 3'd2,
    ALU_SRL = 3'd3,
    ALU_SLL = 3'd4,
    ALU_XOR = 3'd5,
    ALU_AND = 3'd6,
    ALU_SRA = 3'd7
  } alu_op_e;

  localparam alu_op_e BUBBLE_ALU_CTRL = ALU_ADD;
  localparam logic    BUBBLE_VALID    = 1'b0;

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Bundle of ID-side inputs, forwarding buses, stage controls and ALU-side outputs.
// The stage itself is the slave; whoever drives ID and the buses is the master.
interface id_ex_operand_stage_if #(
  parameter int DW = 32,
  parameter int RW = 5
);

  logic          id_valid;
  logic [RW-1:0] id_rs_addr;
  logic [RW-1:0] id_rt_addr;
  logic [DW-1:0] id_rs_data;
  logic [DW-1:0] id_rt_data;
  logic [DW-1:0] id_imm;
  logic [4:0]    id_shamt;
  logic [2:0]    id_alu_ctrl;
  logic          id_alusrc;
  logic          id_shamt_var;
  logic          id_wr_en;
  logic [RW-1:0] id_wr_addr;
  logic          id_mem_read;

  logic          mem_wr_en;
  logic [RW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic          wb_wr_en;
  logic [RW-1:0] wb_wr_addr;
  logic [DW-1:0] wb_wr_data;

  logic          ex_hold;
  logic          ex_flush;

  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [2:0]    alu_ctrl;
  logic [4:0]    alu_s;
  logic          ex_valid;
  logic          ex_wr_en;
  logic [RW-1:0] ex_wr_addr;
  logic          ex_mem_read;
  logic [DW-1:0] ex_rt_fwd;
  logic          load_use_stall;

  modport master (
    output id_valid, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data, id_imm,
           id_shamt, id_alu_ctrl, id_alusrc, id_shamt_var, id_wr_en,
           id_wr_addr, id_mem_read,
           mem_wr_en, mem_wr_addr, mem_wr_data, wb_wr_en, wb_wr_addr, wb_wr_data,
           ex_hold, ex_flush,
    input  alu_a, alu_b, alu_ctrl, alu_s, ex_valid, ex_wr_en, ex_wr_addr,
           ex_mem_read, ex_rt_fwd, load_use_stall
  );

  modport slave (
    input  id_valid, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data, id_imm,
           id_shamt, id_alu_ctrl, id_alusrc, id_shamt_var, id_wr_en,
           id_wr_addr, id_mem_read,
           mem_wr_en, mem_wr_addr, mem_wr_data, wb_wr_en, wb_wr_addr, wb_wr_data,
           ex_hold, ex_flush,
    output alu_a, alu_b, alu_ctrl, alu_s, ex_valid, ex_wr_en, ex_wr_addr,
           ex_mem_read, ex_rt_fwd, load_use_stall
  );

endinterface

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// One operand's forwarding select: MEM beats WB beats the stored value,
// and register $0 always reads as zero.
module id_ex_operand_stage_fwd_mux #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic [RW-1:0] addr,
  input  logic [DW-1:0] stored,
  input  logic          mem_wr_en,
  input  logic [RW-1:0] mem_wr_addr,
  input  logic [DW-1:0] mem_wr_data,
  input  logic          wb_wr_en,
  input  logic [RW-1:0] wb_wr_addr,
  input  logic [DW-1:0] wb_wr_data,
  output logic [DW-1:0] data,
  output logic          hit
);

  logic nonzero;
  logic mem_hit;
  logic wb_hit;

  assign nonzero = (addr != '0);
  assign mem_hit = mem_wr_en && (mem_wr_addr == addr) && nonzero;
  assign wb_hit  = wb_wr_en  && (wb_wr_addr  == addr) && nonzero;
  assign hit     = mem_hit || wb_hit;

  // NOTE: every branch assigns data, so this stays purely combinational.
  always_comb begin
    if (!nonzero)     data = '0;
    else if (mem_hit) data = mem_wr_data;
    else if (wb_hit)  data = wb_wr_data;
    else              data = stored;
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding into the ALU inputs and
// load-use hazard detection back toward ID/PC.
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  id_ex_operand_stage_if.slave       bus
);

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rs_addr;
    logic [RW-1:0] rt_addr;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic [4:0]    shamt;
    alu_op_e       alu_ctrl;
    logic          alusrc;
    logic          shamt_var;
    logic          wr_en;
    logic [RW-1:0] wr_addr;
    logic          mem_read;
  } stage_t;

  function automatic stage_t bubble();
    stage_t b;
    b          = '0;
    b.valid    = BUBBLE_VALID;
    b.alu_ctrl = BUBBLE_ALU_CTRL;
    return b;
  endfunction

  stage_t        stage_q;
  stage_t        stage_d;
  logic [DW-1:0] fwd_rs;
  logic [DW-1:0] fwd_rt;
  logic          rs_hit;
  logic          rt_hit;
  logic          load_use;

  id_ex_operand_stage_fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
    .addr        (stage_q.rs_addr),
    .stored      (stage_q.rs_data),
    .mem_wr_en   (bus.mem_wr_en),
    .mem_wr_addr (bus.mem_wr_addr),
    .mem_wr_data (bus.mem_wr_data),
    .wb_wr_en    (bus.wb_wr_en),
    .wb_wr_addr  (bus.wb_wr_addr),
    .wb_wr_data  (bus.wb_wr_data),
    .data        (fwd_rs),
    .hit         (rs_hit)
  );

  id_ex_operand_stage_fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
    .addr        (stage_q.rt_addr),
    .stored      (stage_q.rt_data),
    .mem_wr_en   (bus.mem_wr_en),
    .mem_wr_addr (bus.mem_wr_addr),
    .mem_wr_data (bus.mem_wr_data),
    .wb_wr_en    (bus.wb_wr_en),
    .wb_wr_addr  (bus.wb_wr_addr),
    .wb_wr_data  (bus.wb_wr_data),
    .data        (fwd_rt),
    .hit         (rt_hit)
  );

  // A held stage cannot take a bubble, so it must not ask ID to stall either.
  assign load_use = stage_q.valid && stage_q.mem_read && (stage_q.wr_addr != '0)
                 && bus.id_valid && !bus.ex_hold
                 && ((stage_q.wr_addr == bus.id_rs_addr)
                  || ((stage_q.wr_addr == bus.id_rt_addr) && !bus.id_alusrc));

  always_comb begin
    stage_d = stage_q;
    if (bus.ex_flush) begin
      stage_d = bubble();
    end else if (bus.ex_hold) begin
      // Absorb write-backs that retire while frozen so they are not lost.
      if (rs_hit) stage_d.rs_data = fwd_rs;
      if (rt_hit) stage_d.rt_data = fwd_rt;
    end else if (load_use || !bus.id_valid) begin
      stage_d = bubble();
    end else begin
      stage_d.valid     = 1'b1;
      stage_d.rs_addr   = bus.id_rs_addr;
      stage_d.rt_addr   = bus.id_rt_addr;
      stage_d.rs_data   = bus.id_rs_data;
      stage_d.rt_data   = bus.id_rt_data;
      stage_d.imm       = bus.id_imm;
      stage_d.shamt     = bus.id_shamt;
      stage_d.alu_ctrl  = alu_op_e'(bus.id_alu_ctrl);
      stage_d.alusrc    = bus.id_alusrc;
      stage_d.shamt_var = bus.id_shamt_var;
      stage_d.wr_en     = bus.id_wr_en;
      stage_d.wr_addr   = bus.id_wr_addr;
      stage_d.mem_read  = bus.id_mem_read;
    end
  end

  // NOTE: reset is sampled on the clock edge only; non-blocking updates keep
  // every flop reading the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst_n) stage_q <= '0;
    else        stage_q <= stage_d;
  end

  assign bus.alu_a          = fwd_rs;
  assign bus.alu_b          = stage_q.alusrc ? stage_q.imm : fwd_rt;
  assign bus.alu_ctrl       = stage_q.alu_ctrl;
  assign bus.alu_s          = stage_q.shamt_var ? fwd_rs[4:0] : stage_q.shamt;
  assign bus.ex_valid       = stage_q.valid;
  assign bus.ex_wr_en       = stage_q.wr_en;
  assign bus.ex_wr_addr     = stage_q.wr_addr;
  assign bus.ex_mem_read    = stage_q.mem_read;
  assign bus.ex_rt_fwd      = fwd_rt;
  assign bus.load_use_stall = load_use;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: expected ALU-side values are queued
// as each step is driven and compared once the stage presents them.
module tb_id_ex_operand_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage_if #(.DW(32), .RW(5)) bus ();

  id_ex_operand_stage #(.DW(32), .RW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ctrl;
    logic [4:0]  s;
    logic        valid;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic expect_out(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] ctrl, input logic [4:0] s, input logic valid);
    exp_t e;
    e.tag = tag; e.a = a; e.b = b; e.ctrl = ctrl; e.s = s; e.valid = valid;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({e.tag, ".alu_a"},    bus.alu_a,    e.a);
      check({e.tag, ".alu_b"},    bus.alu_b,    e.b);
      check({e.tag, ".alu_ctrl"}, {29'd0, bus.alu_ctrl}, {29'd0, e.ctrl});
      check({e.tag, ".alu_s"},    {27'd0, bus.alu_s},    {27'd0, e.s});
      check({e.tag, ".ex_valid"}, {31'd0, bus.ex_valid}, {31'd0, e.valid});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic valid, input logic [4:0] rs, input logic [31:0] rs_d,
                          input logic [4:0] rt, input logic [31:0] rt_d, input logic [31:0] imm,
                          input logic [4:0] shamt, input logic [2:0] ctrl, input logic alusrc,
                          input logic shvar, input logic wr_en, input logic [4:0] wr_addr,
                          input logic mem_read);
    bus.id_valid = valid; bus.id_rs_addr = rs; bus.id_rs_data = rs_d;
    bus.id_rt_addr = rt; bus.id_rt_data = rt_d; bus.id_imm = imm;
    bus.id_shamt = shamt; bus.id_alu_ctrl = ctrl; bus.id_alusrc = alusrc;
    bus.id_shamt_var = shvar; bus.id_wr_en = wr_en; bus.id_wr_addr = wr_addr;
    bus.id_mem_read = mem_read;
  endtask

  task automatic drive_fwd(input logic m_en, input logic [4:0] m_a, input logic [31:0] m_d,
                           input logic w_en, input logic [4:0] w_a, input logic [31:0] w_d);
    bus.mem_wr_en = m_en; bus.mem_wr_addr = m_a; bus.mem_wr_data = m_d;
    bus.wb_wr_en = w_en;  bus.wb_wr_addr = w_a;  bus.wb_wr_data = w_d;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    drive_id(1'b1, 5'd1, 32'h55, 5'd2, 32'h66, 32'h7, 5'd9, 3'd3, 1'b1, 1'b1, 1'b1, 5'd3, 1'b1);
    drive_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    bus.ex_hold = 1'b0; bus.ex_flush = 1'b0;

    // Reset held two cycles with a live instruction on ID.
    for (int i = 0; i < 2; i++) begin
      expect_out("reset", 32'd0, 32'd0, 3'd0, 5'd0, 1'b0);
      tick();
      pop_check();
    end
    check("reset.ex_wr_en",    {31'd0, bus.ex_wr_en},    32'd0);
    check("reset.ex_mem_read", {31'd0, bus.ex_mem_read}, 32'd0);

    // First real add: rs=5, rt=3, one-cycle latency.
    rst_n = 1'b1;
    drive_id(1'b1, 5'd1, 32'h5, 5'd2, 32'h3, 32'h0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0);
    expect_out("add", 32'h5, 32'h3, 3'd0, 5'd0, 1'b1);
    tick();
    pop_check();
    check("add.ex_rt_fwd", bus.ex_rt_fwd, 32'h3);

    // Forward priority on rs=$8; rt=$0 reads as zero despite stored data.
    drive_id(1'b1, 5'd8, 32'h11, 5'd0, 32'h77, 32'h0, 5'd0, 3'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    expect_out("fwd_stored", 32'h11, 32'h0, 3'd2, 5'd0, 1'b1);
    tick();
    pop_check();
    bus.ex_hold = 1'b1;
    drive_fwd(1'b1, 5'd8, 32'hAA, 1'b1, 5'd8, 32'hBB);
    expect_out("fwd_mem_over_wb", 32'hAA, 32'h0, 3'd2, 5'd0, 1'b1);
    #1; pop_check();
    bus.mem_wr_en = 1'b0;
    expect_out("fwd_wb", 32'hBB, 32'h0, 3'd2, 5'd0, 1'b1);
    #1; pop_check();
    bus.ex_hold = 1'b0;
    drive_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    drive_id(1'b1, 5'd0, 32'h99, 5'd0, 32'h0, 32'h0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    drive_fwd(1'b1, 5'd0, 32'hFF, 1'b0, 5'd0, 32'd0);
    expect_out("fwd_r0", 32'h0, 32'h0, 3'd0, 5'd0, 1'b1);
    #1; pop_check();
    drive_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    // Load-use: lw $9 in EX, add using rs=$9 in ID.
    drive_id(1'b1, 5'd1, 32'h100, 5'd9, 32'h0, 32'h4, 5'd0, 3'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b1);
    expect_out("lw_imm", 32'h100, 32'h4, 3'd0, 5'd0, 1'b1);
    tick();
    pop_check();
    drive_id(1'b1, 5'd9, 32'h0, 5'd2, 32'h0, 32'h0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b1, 5'd10, 1'b0);
    #1;
    check("lu_rs.stall", {31'd0, bus.load_use_stall}, 32'd1);
    expect_out("lu_bubble", 32'h0, 32'h0, 3'd0, 5'd0, 1'b0);
    tick();
    pop_check();
    check("lu_bubble.stall", {31'd0, bus.load_use_stall}, 32'd0);
    check("lu_bubble.ex_wr_en", {31'd0, bus.ex_wr_en}, 32'd0);
    drive_id(1'b1, 5'd1, 32'h100, 5'd0, 32'h0, 32'h4, 5'd0, 3'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b1);
    tick();
    drive_id(1'b1, 5'd3, 32'h0, 5'd9, 32'h0, 32'h8, 5'd0, 3'd0, 1'b1, 1'b0, 1'b1, 5'd10, 1'b0);
    #1;
    check("lu_rt_imm.stall", {31'd0, bus.load_use_stall}, 32'd0);
    bus.id_alusrc = 1'b0;
    #1;
    check("lu_rt_reg.stall", {31'd0, bus.load_use_stall}, 32'd1);
    bus.ex_hold = 1'b1;
    #1;
    check("lu_hold.stall", {31'd0, bus.load_use_stall}, 32'd0);
    bus.ex_hold = 1'b0;

    // Hold for three cycles while WB retires $4 in the first one only.
    drive_id(1'b1, 5'd4, 32'h1, 5'd0, 32'h0, 32'h0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0);
    tick();
    drive_id(1'b1, 5'd1, 32'hDEAD, 5'd2, 32'hBEEF, 32'h0, 5'd0, 3'd6, 1'b0, 1'b0, 1'b1, 5'd6, 1'b0);
    bus.ex_hold = 1'b1;
    drive_fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h1234);
    expect_out("hold_c1", 32'h1234, 32'h0, 3'd0, 5'd0, 1'b1);
    #1; pop_check();
    tick();
    drive_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    expect_out("hold_c2", 32'h1234, 32'h0, 3'd0, 5'd0, 1'b1);
    #1; pop_check();
    tick();
    expect_out("hold_c3", 32'h1234, 32'h0, 3'd0, 5'd0, 1'b1);
    pop_check();
    tick();
    bus.ex_hold = 1'b0;
    bus.id_valid = 1'b0;
    expect_out("hold_release", 32'h1234, 32'h0, 3'd0, 5'd0, 1'b1);
    #1; pop_check();

    // Flush and hold together: flush wins.
    drive_id(1'b1, 5'd1, 32'h7, 5'd2, 32'h9, 32'h0, 5'd0, 3'd5, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0);
    expect_out("pre_flush", 32'h7, 32'h9, 3'd5, 5'd0, 1'b1);
    tick();
    pop_check();
    bus.ex_flush = 1'b1; bus.ex_hold = 1'b1;
    expect_out("flush_hold", 32'h0, 32'h0, 3'd0, 5'd0, 1'b0);
    tick();
    pop_check();
    check("flush_hold.ex_wr_en", {31'd0, bus.ex_wr_en}, 32'd0);
    bus.ex_flush = 1'b0; bus.ex_hold = 1'b0;

    // Variable shift: s from forwarded rs low bits vs stored shamt.
    drive_id(1'b1, 5'd6, 32'h1F, 5'd7, 32'h10, 32'h0, 5'd7, 3'd4, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0);
    drive_fwd(1'b1, 5'd6, 32'h23, 1'b0, 5'd0, 32'd0);
    expect_out("sllv", 32'h23, 32'h10, 3'd4, 5'd3, 1'b1);
    tick();
    pop_check();
    bus.id_shamt_var = 1'b0;
    expect_out("sll", 32'h23, 32'h10, 3'd4, 5'd7, 1'b1);
    tick();
    pop_check();

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register plus operand-forwarding stage; directly upstream of the ALU.
- Captures decoded operands and control from ID, resolves RAW hazards by forwarding from EX/MEM and MEM/WB write-back buses, and drives the ALU inputs A, B, ALUctrl and s.
- Also flags load-use hazards back to the hazard/PC logic.

Parameters:
- DW, 32, datapath width
- RW, 5, register address width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs_addr  in  RW  rs index
- id_rt_addr  in  RW  rt index
- id_rs_data  in  DW  register-file rs read
- id_rt_data  in  DW  register-file rt read
- id_imm  in  DW  sign/zero-extended immediate
- id_shamt  in  5  instruction shamt field
- id_alu_ctrl  in  3  ALU op code (0 add, 1 sub, 2 or, 3 srl, 4 sll, 5 xor, 6 and, 7 sra)
- id_alusrc  in  1  1: B = immediate
- id_shamt_var  in  1  1: s = forwarded rs[4:0] (sllv/srlv)
- id_wr_en  in  1  instruction writes a register
- id_wr_addr  in  RW  destination register
- id_mem_read  in  1  instruction is a load
- mem_wr_en, mem_wr_addr, mem_wr_data  in  1/RW/DW  EX/MEM forwarding bus
- wb_wr_en, wb_wr_addr, wb_wr_data  in  1/RW/DW  MEM/WB forwarding bus
- ex_hold  in  1  downstream stall; freeze stage
- ex_flush  in  1  branch/exception squash
- alu_a  out  DW  ALU input A
- alu_b  out  DW  ALU input B
- alu_ctrl  out  3  ALU control
- alu_s  out  5  ALU shift amount
- ex_valid  out  1  stage holds a real instruction
- ex_wr_en, ex_wr_addr, ex_mem_read, ex_rt_fwd  out  1/RW/1/DW  pass-through for EX/MEM; ex_rt_fwd is forwarded rt (store data)
- load_use_stall  out  1  combinational hazard request to ID/PC

Behaviour:
- Reset (rst_n=0 at edge): every stage register 0. ex_valid=0, ex_wr_en=0, ex_mem_read=0, alu_ctrl=0, alu_a=alu_b=0, alu_s=0. Reset overrides all other inputs.
- Update priority per edge: reset > ex_flush > ex_hold > load.
- Load: capture all id_* fields. Latency from ID to ALU inputs is 1 cycle.
- Flush: capture a bubble. Valid, wr_en and mem_read go to 0; data registers go to 0; alu_ctrl goes to 0.
- Bubble on load-use: when load_use_stall=1 and there is no hold or flush, capture a bubble. ID is held externally.
- Hold: registers keep their values, with one exception. Stored rs/rt data is overwritten with the forwarded value whenever a forwarding match exists, so a write-back retiring during the hold is not lost.
- Forwarding is combinational on stored rs/rt, per operand:
  - Match means wr_en && wr_addr==addr && addr!=0.
  - A MEM match beats a WB match, which beats the stored value.
  - Register $0 always reads as 0 regardless of stored data.
- ALU input selection:
  - alu_a = fwd_rs.
  - alu_b = stored imm if alusrc, else fwd_rt.
  - ex_rt_fwd = fwd_rt always.
  - alu_s = fwd_rs[4:0] if shamt_var, else stored shamt.
- load_use_stall = ex_valid && ex_mem_read && ex_wr_addr!=0 && id_valid && (ex_wr_addr==id_rs_addr || (ex_wr_addr==id_rt_addr && !id_alusrc)). It is forced to 0 while ex_hold=1.
- Outputs of an invalid stage are don't-care downstream but must equal the bubble values.
- Simultaneous flush and hold: flush wins.
- Simultaneous MEM and WB writes to the same register: the MEM value is used.

Decomposition:
- Shared package holds the ALU op constants (ALU_ADD=0 … ALU_SRA=7), DW/RW defaults, and the bubble values.
- One sub-module, fwd_mux: address compare plus 3:1 priority select. It is instantiated twice, for rs and rt.

Test Plan:
- Reset: rst_n=0 for 2 cycles with id_valid=1 driven → all outputs 0 and ex_valid=0. Release, then add rs=0x5, rt=0x3 → next cycle alu_a=5, alu_b=3, alu_ctrl=0.
- Forward priority: stored rs=$8 (data 0x11), mem_wr($8,0xAA), wb_wr($8,0xBB) → alu_a=0xAA. Drop mem_wr → alu_a=0xBB. Target $0 with mem_wr data 0xFF → alu_a=0.
- Load-use: EX holds lw $9 and ID has add using rs=$9 → load_use_stall=1. Next cycle ex_valid=0 (bubble) and load_use_stall=0. If rt=$9 with id_alusrc=1 and rs≠$9 → no stall.
- Hold with write-back: ex_hold=1 for 3 cycles, wb_wr($4,0x1234) in cycle 1 only, stored rs=$4 → alu_a=0x1234 in cycles 2-3 and after release.
- Flush vs hold: ex_flush=1 and ex_hold=1 together → next cycle ex_valid=0, ex_wr_en=0, alu_ctrl=0.
- Variable shift: sllv with rs forwarded from MEM = 0x23, id_shamt=7, id_shamt_var=1 → alu_s=3. With id_shamt_var=0 → alu_s=7.
